// File: rtl/regfile_write_bank.sv
// Write side of the CPU register file: decoded write enables, storage for
// registers 0..NREGS-2, a hardwired zero top register and a registered write ack.
module regfile_write_bank #(
    parameter int WIDTH  = 64,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    output logic [NREGS*WIDTH-1:0]  q,
    output logic                    wr_ack,
    output logic [ADDR_W-1:0]       ack_addr
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(NREGS - 1);

    logic [NREGS-2:0] en;
    logic             commit;

    // The zero register has no decode line, so a write aimed at it reaches no storage.
    always_comb begin
        en = '0;
        for (int i = 0; i < NREGS - 1; i++) begin
            en[i] = wr_en && (wr_addr == ADDR_W'(i));
        end
    end

    assign commit = wr_en && (wr_addr != ZERO_IDX);

    for (genvar i = 0; i < NREGS - 1; i++) begin : g_reg
        logic [WIDTH-1:0] value;

        always_ff @(posedge clk) begin
            if (reset) begin
                value <= '0;
            end else if (en[i]) begin
                value <= wr_data;
            end
        end

        assign q[i*WIDTH +: WIDTH] = value;
    end

    assign q[(NREGS-1)*WIDTH +: WIDTH] = '0;

    // ack_addr only follows committed writes, so it still names the last real write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ack   <= 1'b0;
            ack_addr <= '0;
        end else begin
            wr_ack <= commit;
            if (commit) begin
                ack_addr <= wr_addr;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Self-checking bench for regfile_write_bank: directed vector table, exhaustive
// decode sweep and randomized traffic against an array-based reference model.
module tb_regfile_write_bank;

    localparam int WIDTH  = 64;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    logic                   clk;
    logic                   reset;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic [NREGS*WIDTH-1:0] q;
    logic                   wr_ack;
    logic [ADDR_W-1:0]      ack_addr;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0]  model_regs [NREGS];
    logic              model_ack;
    logic [ADDR_W-1:0] model_ack_addr;

    typedef struct {
        logic              rst;
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
        logic              exp_ack;
        logic [ADDR_W-1:0] exp_ack_addr;
        int                chk_idx;
        logic [WIDTH-1:0]  chk_val;
    } vec_t;

    vec_t vecs [12];

    regfile_write_bank #(
        .WIDTH  (WIDTH),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .q        (q),
        .wr_ack   (wr_ack),
        .ack_addr (ack_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] regOf(input int idx);
        return q[idx*WIDTH +: WIDTH];
    endfunction

    // Architectural behaviour: the top index reads zero and never commits.
    task automatic modelStep(input logic rst, input logic en, input logic [ADDR_W-1:0] addr,
                             input logic [WIDTH-1:0] data);
        if (rst) begin
            for (int i = 0; i < NREGS; i++) model_regs[i] = '0;
            model_ack      = 1'b0;
            model_ack_addr = '0;
        end else if (en && (int'(addr) != NREGS - 1)) begin
            model_regs[addr] = data;
            model_ack        = 1'b1;
            model_ack_addr   = addr;
        end else begin
            model_ack = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [ADDR_W-1:0] addr,
                                 input logic [WIDTH-1:0] data);
        @(negedge clk);
        reset   = rst;
        wr_en   = en;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk);
        #1;
        modelStep(rst, en, addr, data);
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic checkRegs(input string name);
        int bad;
        bad = -1;
        checks++;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (regOf(i) !== model_regs[i]) bad = i;
        end
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL %s reg=%0d actual=%h expected=%h", name, bad, regOf(bad), model_regs[bad]);
        end
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < NREGS; i++) model_regs[i] = 'x;
        model_ack      = 1'bx;
        model_ack_addr = 'x;

        vecs[0]  = '{1'b1, 1'b1, 5'd3,  64'hFFFF,                1'b0, 5'd0,  3,  64'h0};
        vecs[1]  = '{1'b0, 1'b1, 5'd5,  64'h0123_4567_89AB_CDEF, 1'b1, 5'd5,  5,  64'h0123_4567_89AB_CDEF};
        vecs[2]  = '{1'b0, 1'b0, 5'd7,  64'hDEAD,                1'b0, 5'd5,  7,  64'h0};
        vecs[3]  = '{1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd5,  31, 64'h0};
        vecs[4]  = '{1'b0, 1'b1, 5'd0,  64'd1,                   1'b1, 5'd0,  0,  64'd1};
        vecs[5]  = '{1'b0, 1'b1, 5'd30, 64'd2,                   1'b1, 5'd30, 30, 64'd2};
        vecs[6]  = '{1'b0, 1'b1, 5'd0,  64'd3,                   1'b1, 5'd0,  0,  64'd3};
        vecs[7]  = '{1'b0, 1'b0, 5'd0,  64'd9,                   1'b0, 5'd0,  30, 64'd2};
        vecs[8]  = '{1'b0, 1'b1, 5'd3,  64'h55,                  1'b1, 5'd3,  3,  64'h55};
        vecs[9]  = '{1'b1, 1'b1, 5'd3,  64'hFFFF,                1'b0, 5'd0,  3,  64'h0};
        vecs[10] = '{1'b0, 1'b0, 5'd5,  64'h0,                   1'b0, 5'd0,  5,  64'h0};
        vecs[11] = '{1'b0, 1'b1, 5'd2,  64'd7,                   1'b1, 5'd2,  2,  64'd7};

        applyStimulus(1'b1, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("reset_ack", 64'(wr_ack), 64'h0);
        checkOutput("reset_ack_addr", 64'(ack_addr), 64'h0);
        for (int i = 0; i < NREGS; i++) checkOutput($sformatf("reset_q%0d", i), regOf(i), 64'h0);

        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].en, vecs[v].addr, vecs[v].data);
            checkOutput($sformatf("vec%0d_ack", v), 64'(wr_ack), 64'(vecs[v].exp_ack));
            checkOutput($sformatf("vec%0d_ack_addr", v), 64'(ack_addr), 64'(vecs[v].exp_ack_addr));
            checkOutput($sformatf("vec%0d_q%0d", v, vecs[v].chk_idx), regOf(vecs[v].chk_idx), vecs[v].chk_val);
            checkRegs($sformatf("vec%0d_regs", v));
        end

        // Exhaustive decode: every step must touch only its own register.
        applyStimulus(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < NREGS - 1; i++) begin
            applyStimulus(1'b0, 1'b1, ADDR_W'(i), 64'(i + 1));
            checkOutput($sformatf("decode%0d_ack_addr", i), 64'(ack_addr), 64'(i));
            checkRegs($sformatf("decode%0d_regs", i));
        end
        applyStimulus(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("decode_x31_ack", 64'(wr_ack), 64'h0);
        checkOutput("decode_x31_ack_addr", 64'(ack_addr), 64'd30);
        for (int i = 0; i < NREGS; i++) begin
            checkOutput($sformatf("scan_q%0d", i), regOf(i), (i == NREGS - 1) ? 64'h0 : 64'(i + 1));
        end

        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 7) == 0) ? 5'd31 : ADDR_W'($urandom_range(0, NREGS - 1)),
                          {$urandom, $urandom});
            checkOutput($sformatf("rand%0d_ack", n), 64'(wr_ack), 64'(model_ack));
            checkOutput($sformatf("rand%0d_ack_addr", n), 64'(ack_addr), 64'(model_ack_addr));
            checkRegs($sformatf("rand%0d_regs", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
